muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised iterative multiply/divide unit for the EX stage, replacing the combinational `mult`/`multu` path and the external fixed-width divider. It computes signed/unsigned multiply, multiply-accumulate/subtract against HI/LO, and signed/unsigned divide over `WIDTH`-bit operands. The unit uses a start/ready/annul handshake, and the pipeline stalls EX while `busy_o` is high. Results are returned as a packed `{hi, lo}` pair for the HI/LO write-back path.

## Interface
- `WIDTH`, 32, operand width; result width is 2*`WIDTH`; must be >= 4.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `start_i`  in  1  request; sampled only in IDLE or DONE.
- `op_i`  in  3  operation, a `md_op_t` value.
- `a_i`  in  `WIDTH`  operand A: multiplicand or dividend.
- `b_i`  in  `WIDTH`  operand B: multiplier or divisor.
- `hilo_i`  in  2*`WIDTH`  current `{hi, lo}` accumulator for MADD/MSUB; sampled together with `start_i`.
- `annul_i`  in  1  abort the operation in flight (exception or flush).
- `busy_o`  out  1  operation in progress; EX stall request.
- `ready_o`  out  1  one-cycle pulse when `result_o` is newly valid.
- `result_o`  out  2*`WIDTH`  `{hi, lo}`; for divide, hi = remainder and lo = quotient.
- `div_zero_o`  out  1  set with `ready_o` when a divide had `b_i` == 0; holds until the next accepted start.

## Operation
- **States:** IDLE, CALC, FIX, DONE.
- **Accept:** when `start_i`=1 and `annul_i`=0 in IDLE or DONE, latch `op_i`, `|a|`, `|b|`, the sign flags and `hilo_i`.
  - Signed ops take magnitudes; unsigned ops use operands as-is.
  - Next state is CALC, except a divide with `b_i`==0, which goes directly to FIX.
- **CALC:** runs exactly `WIDTH` iterations, one per cycle.
  - Multiply: radix-2 shift-add, producing a 2*`WIDTH` unsigned product.
  - Divide: radix-2 restoring, producing a `WIDTH` quotient and `WIDTH` remainder.
  - An iteration counter goes 0..`WIDTH`-1; after the last iteration the state moves to FIX.
- **FIX:** one cycle that applies sign correction and the accumulate, then moves to DONE.
  - Product is negated if sign(a) XOR sign(b) (signed ops only).
  - Quotient is negated if sign(a) XOR sign(b); remainder takes the sign of the dividend.
  - MADD/MADDU: `hilo + product`. MSUB/MSUBU: `hilo - product`. Both wrap modulo 2^(2*`WIDTH`); there is no overflow flag.
  - Divide by zero: quotient = all ones, remainder = `a_i`, `div_zero_o`=1.
  - Signed MIN / -1 gives quotient = MIN and remainder = 0; this falls out of the unsigned magnitude path.
- **DONE:** `ready_o`=1 for this cycle only.
  - Next state is IDLE, or CALC/FIX if a new start is accepted in the same cycle (back-to-back issue).
- **Result hold:** `result_o` is registered and updated only on entry to DONE. It holds between operations and through annulled ones.
- **Start while busy:** `start_i` in CALC or FIX is ignored.
- **Annul:**
  - `annul_i`=1 in CALC or FIX sends the state to IDLE on the next edge, with no `ready_o` and with `result_o`/`div_zero_o` unchanged.
  - `annul_i` together with `start_i` in IDLE/DONE: annul wins and nothing is accepted.
- **Invalid `op_i`:** encodings 6..7 are treated as MULTU.

## Timing
- **Reset:** state IDLE, counter 0, `busy_o`=0, `ready_o`=0, `result_o`=0, `div_zero_o`=0. Reset applies from any state, including mid-CALC.
- **Normal latency:** start sampled at edge k.
  - CALC during cycles k+1..k+`WIDTH`.
  - FIX at k+`WIDTH`+1.
  - DONE (`ready_o`=1) at k+`WIDTH`+2, i.e. 34 cycles for `WIDTH`=32.
- **Divide-by-zero latency:** FIX at k+1, DONE at k+2.
- **`busy_o`:** high exactly in CALC and FIX; low in IDLE and DONE.
- **Throughput:** one operation per `WIDTH`+2 cycles with back-to-back starts in DONE.

## Structure
- **Package `muldiv_pkg`:**
  - `md_op_t` (3 bits): MD_MULT=0, MD_MULTU=1, MD_MADD=2, MD_MADDU=3, MD_MSUB=4, MD_MSUBU=5, MD_DIV=6, MD_DIVU=7. With this encoding the two divides are 6..7, and the "6..7 → MULTU" rule in Operation must be removed.
  - `md_state_t` for the four states.
  - `md_is_signed()` and `md_is_div()` helper functions.
- **Sub-module `md_step`:** one combinational iteration (shift-add step or trial-subtract step) parametrised by `WIDTH`. The FSM, registers and FIX logic live in `muldiv_unit`.
- **Decoder:** the existing ALU decoder maps `EXE_*` ops to `md_op_t`.

## Test plan
- **MULT:** `a`=0xFFFFFFFD (-3), `b`=7 → `ready_o` at k+34, `result_o`=0xFFFFFFFF_FFFFFFEB, `busy_o` high for 33 cycles.
- **DIVU and DIV:**
  - DIVU 100/7 → hi=0x2, lo=0xE.
  - DIV -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- **Divide by zero:** DIV 5/0 → `ready_o` at k+2, lo=0xFFFFFFFF, hi=0x5, `div_zero_o`=1. A following MULT 2×3 clears `div_zero_o` and gives result 0x6.
- **Accumulate:**
  - MADD with `hilo`=0x10, `a`=-1, `b`=1 → 0xF.
  - MSUBU with `hilo`=0, `a`=1, `b`=1 → 0xFFFFFFFF_FFFFFFFF.
- **Annul and ignored start:**
  - `annul_i` at the 10th CALC cycle → `busy_o`=0 next cycle, no `ready_o`, `result_o` keeps its previous value.
  - `start_i` together with `annul_i` in IDLE → not accepted.
- **Back-to-back and reset:**
  - A new start in the DONE cycle yields a second `ready_o` exactly 34 cycles later.
  - `rst_i` mid-CALC → all outputs 0 on the next cycle, and a start after that completes correctly.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and op-classification helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_MADD  = 3'd2,
    MD_MADDU = 3'd3,
    MD_MSUB  = 3'd4,
    MD_MSUBU = 3'd5,
    MD_DIV   = 3'd6,
    MD_DIVU  = 3'd7
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_t;

  function automatic logic md_is_signed(input md_op_t op);
    case (op)
      MD_MULT, MD_MADD, MD_MSUB, MD_DIV: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  function automatic logic md_is_div(input md_op_t op);
    case (op)
      MD_DIV, MD_DIVU: return 1'b1;
      default:         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/md_step.sv
// One radix-2 iteration: shift-add for multiply, restoring trial-subtract for divide.
// acc holds {hi, lo}: multiplier bits drain from lo (mul), dividend bits shift out of lo into hi (div).
module md_step #(
  parameter int WIDTH = 32
) (
  input  logic               div_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] diff_s;

  // Single iteration datapath for either operation.
  always_comb begin
    sum_s     = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
              + (acc_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
    shifted_s = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
    diff_s    = shifted_s - {1'b0, opnd_i};
    acc_o     = acc_i;
    if (div_i) begin
      if (!diff_s[WIDTH]) begin
        acc_o = {diff_s[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = {shifted_s[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o = {sum_s, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply / multiply-accumulate / divide unit with start/ready/annul handshake.
// Magnitudes are computed at accept; sign correction and accumulate happen in the FIX cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [2:0]         op_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [2*WIDTH-1:0] hilo_i,
  input  logic               annul_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               div_zero_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  md_state_t          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  md_op_t             op_q, op_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] hilo_q, hilo_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_a_q, neg_a_d;
  logic               dz_q, dz_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               div_zero_q, div_zero_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;

  md_op_t             op_in_s;
  logic               a_neg_s, b_neg_s, in_div_s, b_zero_s, accept_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic [2*WIDTH-1:0] step_s;
  logic [2*WIDTH-1:0] prod_s, fix_res_s;
  logic [WIDTH-1:0]   quo_s, rem_s;

  md_step #(.WIDTH(WIDTH)) u_step (
    .div_i  (md_is_div(op_q)),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (step_s)
  );

  // Operand decode at accept time.
  always_comb begin
    op_in_s  = md_op_t'(op_i);
    in_div_s = md_is_div(op_in_s);
    a_neg_s  = md_is_signed(op_in_s) & a_i[WIDTH-1];
    b_neg_s  = md_is_signed(op_in_s) & b_i[WIDTH-1];
    a_mag_s  = a_neg_s ? -a_i : a_i;
    b_mag_s  = b_neg_s ? -b_i : b_i;
    b_zero_s = (b_i == {WIDTH{1'b0}});
    accept_s = start_i & ~annul_i & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  end

  // Sign correction and accumulate applied in FIX.
  always_comb begin
    prod_s = neg_res_q ? -acc_q : acc_q;
    quo_s  = acc_q[WIDTH-1:0];
    rem_s  = acc_q[2*WIDTH-1:WIDTH];
    case (op_q)
      MD_MADD, MD_MADDU: fix_res_s = hilo_q + prod_s;
      MD_MSUB, MD_MSUBU: fix_res_s = hilo_q - prod_s;
      MD_DIV, MD_DIVU: begin
        // On divide-by-zero lo still holds |a|; restoring its sign recovers a_i.
        if (dz_q) begin
          fix_res_s = {(neg_a_q ? -quo_s : quo_s), {WIDTH{1'b1}}};
        end else begin
          fix_res_s = {(neg_a_q ? -rem_s : rem_s), (neg_res_q ? -quo_s : quo_s)};
        end
      end
      default:           fix_res_s = prod_s;
    endcase
  end

  // FSM next-state and datapath load/iterate.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    hilo_d     = hilo_q;
    neg_res_d  = neg_res_q;
    neg_a_d    = neg_a_q;
    dz_d       = dz_q;
    result_d   = result_q;
    div_zero_d = div_zero_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          op_d       = op_in_s;
          hilo_d     = hilo_i;
          neg_res_d  = a_neg_s ^ b_neg_s;
          neg_a_d    = a_neg_s;
          dz_d       = in_div_s & b_zero_s;
          div_zero_d = 1'b0;
          cnt_d      = {CW{1'b0}};
          opnd_d     = in_div_s ? b_mag_s : a_mag_s;
          acc_d      = {{WIDTH{1'b0}}, (in_div_s ? a_mag_s : b_mag_s)};
          state_d    = (in_div_s & b_zero_s) ? ST_FIX : ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (annul_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          acc_d   = step_s;
          cnt_d   = {CW{1'b0}};
          state_d = ST_FIX;
        end else begin
          acc_d = step_s;
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_FIX: begin
        if (annul_i) begin
          state_d = ST_IDLE;
        end else begin
          result_d   = fix_res_s;
          div_zero_d = dz_q;
          state_d    = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_DONE);
    busy_d  = (state_d == ST_CALC) | (state_d == ST_FIX);
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {CW{1'b0}};
      op_q       <= MD_MULT;
      opnd_q     <= {WIDTH{1'b0}};
      acc_q      <= {(2*WIDTH){1'b0}};
      hilo_q     <= {(2*WIDTH){1'b0}};
      neg_res_q  <= 1'b0;
      neg_a_q    <= 1'b0;
      dz_q       <= 1'b0;
      result_q   <= {(2*WIDTH){1'b0}};
      div_zero_q <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      hilo_q     <= hilo_d;
      neg_res_q  <= neg_res_d;
      neg_a_q    <= neg_a_d;
      dz_q       <= dz_d;
      result_q   <= result_d;
      div_zero_q <= div_zero_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign busy_o     = busy_q;
  assign ready_o    = ready_q;
  assign result_o   = result_q;
  assign div_zero_o = div_zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes model results, a negedge monitor pops on ready_o.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam int LAT_NORM = W + 2;  // counting the issue cycle
  localparam int LAT_DZ   = 2;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic [2:0]    op_i = 3'd0;
  logic [W-1:0]  a_i = '0;
  logic [W-1:0]  b_i = '0;
  logic [2*W-1:0] hilo_i = '0;
  logic          annul_i = 1'b0;
  logic          busy_o, ready_o, div_zero_o;
  logic [2*W-1:0] result_o;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .hilo_i(hilo_i), .annul_i(annul_i),
    .busy_o(busy_o), .ready_o(ready_o), .result_o(result_o), .div_zero_o(div_zero_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] res;
    logic        dz;
    int          issue;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          issue_edge = 0;
  logic [63:0] last_res = 64'd0;
  logic        last_dz = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Reference: plain arithmetic on the architectural meaning of each op.
  function automatic logic [64:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] hilo);
    logic [63:0] sp, up, r;
    logic        dz;
    int          sa, sb;
    sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    up = {32'd0, a} * {32'd0, b};
    dz = 1'b0;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      3'd0: r = sp;
      3'd1: r = up;
      3'd2: r = hilo + sp;
      3'd3: r = hilo + up;
      3'd4: r = hilo - sp;
      3'd5: r = hilo - up;
      3'd6: begin
        if (b == 32'd0) begin
          r = {a, 32'hFFFF_FFFF}; dz = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          r = {32'd0, 32'h8000_0000};
        end else begin
          r = {32'(sa % sb), 32'(sa / sb)};
        end
      end
      default: begin
        if (b == 32'd0) begin
          r = {a, 32'hFFFF_FFFF}; dz = 1'b1;
        end else begin
          r = {a % b, a / b};
        end
      end
    endcase
    return {dz, r};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk_i) begin
    if (!rst_i && ready_o) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got ready_o=1 at cycle %0d expected no result", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result", result_o, e.res);
        check("div_zero", {63'd0, div_zero_o}, {63'd0, e.dz});
        check("latency", 64'(cyc - e.issue + 1), 64'(e.lat));
        last_res = e.res;
        last_dz  = e.dz;
      end
    end
  end

  // Caller is at a negedge; returns at the negedge after the accepting edge.
  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] hilo);
    op_i = op; a_i = a; b_i = b; hilo_i = hilo; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    issue_edge = cyc;
  endtask

  task automatic push(input logic [63:0] res, input logic dz);
    exp_t e;
    e.res = res; e.dz = dz; e.issue = issue_edge;
    e.lat = dz ? LAT_DZ : LAT_NORM;
    sb_q.push_back(e);
  endtask

  task automatic issue_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [63:0] hilo);
    logic [64:0] m;
    m = model(op, a, b, hilo);
    drive(op, a, b, hilo);
    push(m[63:0], m[64]);
  endtask

  task automatic issue_exp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] hilo, input logic [63:0] xres, input logic xdz);
    drive(op, a, b, hilo);
    push(xres, xdz);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (sb_q.size() == 0 && !busy_o && !ready_o) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got busy_o=%0b pending=%0d expected idle", busy_o, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic wait_ready();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (ready_o) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got no ready_o expected one within 200 cycles");
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("reset_busy", {63'd0, busy_o}, 64'd0);
    check("reset_ready", {63'd0, ready_o}, 64'd0);
    check("reset_result", result_o, 64'd0);
    check("reset_dz", {63'd0, div_zero_o}, 64'd0);

    // MULT -3 * 7 with busy-length measurement.
    issue_exp(3'd0, 32'hFFFF_FFFD, 32'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (busy_o) n++;
      if (ready_o) break;
      @(negedge clk_i);
    end
    check("mult_busy_cycles", 64'(n), 64'd33);
    wait_idle();

    issue_exp(3'd7, 32'd100, 32'd7, 64'd0, {32'd2, 32'd14}, 1'b0);
    wait_idle();
    issue_exp(3'd6, 32'hFFFF_FFF9, 32'd2, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    wait_idle();
    issue_exp(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 64'h0000_0000_8000_0000, 1'b0);
    wait_idle();
    issue_exp(3'd6, 32'd5, 32'd0, 64'd0, 64'h0000_0005_FFFF_FFFF, 1'b1);
    wait_idle();
    check("dz_hold", {63'd0, div_zero_o}, 64'd1);
    issue_exp(3'd0, 32'd2, 32'd3, 64'd0, 64'd6, 1'b0);
    wait_idle();
    issue_exp(3'd2, 32'hFFFF_FFFF, 32'd1, 64'h10, 64'hF, 1'b0);
    wait_idle();
    issue_exp(3'd5, 32'd1, 32'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    wait_idle();

    // Start during CALC must be ignored.
    issue_exp(3'd1, 32'd9, 32'd11, 64'd0, 64'd99, 1'b0);
    repeat (4) @(negedge clk_i);
    op_i = 3'd7; a_i = 32'd1; b_i = 32'd0; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_idle();

    // Annul at the 10th CALC cycle.
    drive(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 64'd0);
    repeat (9) @(negedge clk_i);
    annul_i = 1'b1;
    @(negedge clk_i);
    annul_i = 1'b0;
    check("annul_busy", {63'd0, busy_o}, 64'd0);
    check("annul_result_hold", result_o, last_res);
    repeat (40) @(negedge clk_i);
    check("annul_result_late", result_o, last_res);

    // Annul a divide-by-zero while it sits in FIX.
    drive(3'd7, 32'd3, 32'd0, 64'd0);
    annul_i = 1'b1;
    @(negedge clk_i);
    annul_i = 1'b0;
    check("annul_fix_busy", {63'd0, busy_o}, 64'd0);
    check("annul_fix_dz", {63'd0, div_zero_o}, {63'd0, last_dz});
    repeat (5) @(negedge clk_i);

    // Start together with annul in IDLE is not accepted.
    op_i = 3'd0; a_i = 32'd4; b_i = 32'd4; start_i = 1'b1; annul_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; annul_i = 1'b0;
    check("start_annul_busy", {63'd0, busy_o}, 64'd0);
    repeat (40) @(negedge clk_i);

    // Back-to-back issue from DONE.
    issue_model(3'd1, 32'hDEAD_BEEF, 32'h0000_1001, 64'd0);
    wait_ready();
    issue_model(3'd6, 32'hFFFF_FF00, 32'd7, 64'd0);
    wait_idle();

    // Reset mid-CALC.
    drive(3'd0, 32'd77, 32'd88, 64'd0);
    repeat (5) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("rst_busy", {63'd0, busy_o}, 64'd0);
    check("rst_ready", {63'd0, ready_o}, 64'd0);
    check("rst_result", result_o, 64'd0);
    check("rst_dz", {63'd0, div_zero_o}, 64'd0);
    last_res = 64'd0; last_dz = 1'b0;
    issue_exp(3'd7, 32'd1000, 32'd10, 64'd0, {32'd0, 32'd100}, 1'b0);
    wait_idle();

    // Randomized traffic, mixing idle gaps and back-to-back issue.
    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 15));
        default: rb = rb;
      endcase
      if ((i % 3) == 0 && sb_q.size() != 0) wait_ready();
      else wait_idle();
      issue_model(rop, ra, rb, {$urandom, $urandom});
    end
    wait_idle();
    check("final_result_hold", result_o, last_res);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
